// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the debug loader,
// the MEMORY_ACCESS data port and the FETCH instruction port. One access in
// flight at a time; fixed priority dbg > dm > if, with fetch promoted over dm
// after STARVE_LIMIT consecutive lost arbitrations.
// Optional grant/conflict counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int LAT_CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_req,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_wstrb,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_dbg_cnt,
  output logic [31:0]     perf_dm_cnt,
  output logic [31:0]     perf_if_cnt,
  output logic [31:0]     perf_conflict_cnt
`endif
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]      STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST   = LAT_CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_DM, OWN_IF} owner_t;

  state_t                 state;
  owner_t                 owner;
  owner_t                 win;
  logic                   owner_we;
  logic [SC_W-1:0]        starve_cnt;
  logic [LAT_CNT_W-1:0]   lat_cnt;

  // Arbitration: only in IDLE, and suppressed during reset so all outputs read 0
  always_comb begin
    win = OWN_NONE;
    if (state == S_IDLE && !rst) begin
      if (dbg_req)                                     win = OWN_DBG;
      else if (dm_req && if_req && starve_cnt == STARVE_MAX) win = OWN_IF;
      else if (dm_req)                                 win = OWN_DM;
      else if (if_req)                                 win = OWN_IF;
    end
  end

  // Issue path: drive the memory and the grant from the winner in the same cycle
  always_comb begin
    dbg_gnt   = 1'b0;
    dm_gnt    = 1'b0;
    if_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (win)
      OWN_DBG: begin
        dbg_gnt   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_wstrb = '1;
      end
      OWN_DM: begin
        dm_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_wstrb = dm_wstrb;
      end
      OWN_IF: begin
        if_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = if_addr;
      end
      default: ;
    endcase
  end

  // Access FSM: latency count, read-data capture, one-cycle response pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_NONE;
      owner_we   <= 1'b0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      dbg_rvalid <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      if_rdata   <= '0;
    end else begin
      dbg_rvalid <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rvalid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win != OWN_NONE) begin
            owner    <= win;
            owner_we <= mem_we;
            lat_cnt  <= LAT_CNT_W'(1);
            state    <= S_WAIT;
            if (win == OWN_IF)
              starve_cnt <= '0;
            else if (if_req && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            state   <= S_RESP;
            case (owner)
              OWN_DBG: dbg_rvalid <= 1'b1;
              OWN_DM: begin
                dm_rvalid <= 1'b1;
                if (!owner_we) dm_rdata <= mem_rdata;
              end
              OWN_IF: begin
                if_rvalid <= 1'b1;
                if_rdata  <= mem_rdata;
              end
              default: ;
            endcase
          end else begin
            lat_cnt <= lat_cnt + LAT_CNT_W'(1);
          end
        end
        S_RESP: begin
          owner <= OWN_NONE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (state == S_IDLE) &&
                    ((dbg_req & dm_req) | (dbg_req & if_req) | (dm_req & if_req));

  // Grant and conflict counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dbg_cnt      <= '0;
      perf_dm_cnt       <= '0;
      perf_if_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (dbg_gnt)  perf_dbg_cnt      <= perf_dbg_cnt + 32'd1;
      if (dm_gnt)   perf_dm_cnt       <= perf_dm_cnt + 32'd1;
      if (if_gnt)   perf_if_cnt       <= perf_if_cnt + 32'd1;
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized request
// mixes, checked against a transaction-level model (priority rule, starvation
// counter, word memory with byte strobes).
module tb_mem_port_arbiter;
  localparam int XLEN  = 32;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_req, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata;
  logic dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0] dm_wstrb;
  logic if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_dbg_cnt, perf_dm_cnt, perf_if_cnt, perf_conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT), .LAT_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_dbg_cnt(perf_dbg_cnt), .perf_dm_cnt(perf_dm_cnt),
    .perf_if_cnt(perf_if_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  function automatic logic [31:0] init_val(input logic [5:0] idx);
    return ({26'd0, idx} * 32'h9E37_79B1) + 32'h0000_1234;
  endfunction

  // Memory macro stand-in: responds to whatever the arbiter puts on mem_*
  logic [31:0] emu_mem [64];
  bit          emu_wr  [64];
  logic [31:0] pipe    [LAT];
  logic [31:0] wcur;
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        wcur = emu_wr[mem_addr[7:2]] ? emu_mem[mem_addr[7:2]] : init_val(mem_addr[7:2]);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) wcur[b*8 +: 8] = mem_wdata[b*8 +: 8];
        emu_mem[mem_addr[7:2]] <= wcur;
        emu_wr[mem_addr[7:2]]  <= 1'b1;
        pipe[0] <= $urandom;
      end else begin
        pipe[0] <= emu_wr[mem_addr[7:2]] ? emu_mem[mem_addr[7:2]] : init_val(mem_addr[7:2]);
      end
    end else begin
      pipe[0] <= $urandom;
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model state
  int n_cmp = 0;
  int n_bad = 0;
  bit pend_dbg, pend_dm, pend_if;
  logic [31:0] q_dbg_addr, q_dbg_data, q_dm_addr, q_dm_wdata, q_if_addr;
  logic q_dm_we;
  logic [3:0] q_dm_wstrb;
  int starve;
  logic [31:0] exp_dm_rdata, exp_if_rdata;
  logic [31:0] ref_mem [64];
  bit          ref_wr  [64];
  int m_dbg, m_dm, m_if, m_conf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [5:0] idx);
    return ref_wr[idx] ? ref_mem[idx] : init_val(idx);
  endfunction

  task automatic ref_write(input logic [5:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ref_read(idx);
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[idx] = w;
    ref_wr[idx]  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_dbg(input logic [31:0] a, input logic [31:0] d);
    pend_dbg = 1; q_dbg_addr = a; q_dbg_data = d;
    dbg_req = 1'b1; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic req_dm(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    pend_dm = 1; q_dm_we = we; q_dm_addr = a; q_dm_wdata = d; q_dm_wstrb = s;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d; dm_wstrb = s;
  endtask

  task automatic req_if(input logic [31:0] a);
    pend_if = 1; q_if_addr = a;
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
    chk({tag, "_rvalid"}, 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
    chk({tag, "_mem_ctl"}, 32'({mem_en, mem_we, mem_wstrb}), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
  endtask

  // One arbitration starting in an IDLE cycle (called at posedge+1 with
  // requests already driven); follows the winner through to its response.
  task automatic run_round(output int who, output logic [2:0] gv);
    int npend;
    logic [31:0] e_addr, e_wdata, rd;
    logic e_we;
    logic [3:0] e_strb;
    rd = '0;
    npend = int'(pend_dbg) + int'(pend_dm) + int'(pend_if);
    if (pend_dbg)                                   who = 1;
    else if (pend_dm && pend_if && starve == LIMIT) who = 3;
    else if (pend_dm)                               who = 2;
    else if (pend_if)                               who = 3;
    else                                            who = 0;
    case (who)
      1: begin e_we = 1; e_addr = q_dbg_addr; e_wdata = q_dbg_data; e_strb = 4'hF; end
      2: begin e_we = q_dm_we; e_addr = q_dm_addr; e_wdata = q_dm_wdata; e_strb = q_dm_wstrb; end
      3: begin e_we = 0; e_addr = q_if_addr; e_wdata = 0; e_strb = 4'h0; end
      default: begin e_we = 0; e_addr = 0; e_wdata = 0; e_strb = 4'h0; end
    endcase
    @(negedge clk);
    gv = {dbg_gnt, dm_gnt, if_gnt};
    chk("issue_gnt", 32'(gv), 32'({who == 1, who == 2, who == 3}));
    chk("issue_mem_en", 32'(mem_en), 32'(who != 0));
    chk("issue_mem_we", 32'(mem_we), 32'(e_we));
    chk("issue_mem_addr", mem_addr, e_addr);
    chk("issue_mem_wdata", mem_wdata, e_wdata);
    chk("issue_mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
    if (npend >= 2) m_conf++;
    if (who == 0) return;
    if (who == 1) m_dbg++;
    if (who == 2) m_dm++;
    if (who == 3) m_if++;
    if (who == 3) starve = 0;
    else if (pend_if && starve < LIMIT) starve++;
    if (e_we) ref_write(e_addr[7:2], e_wdata, e_strb);
    else rd = ref_read(e_addr[7:2]);
    step();
    case (who)
      1: begin dbg_req = 1'b0; pend_dbg = 0; end
      2: begin dm_req = 1'b0; pend_dm = 0; end
      default: begin if_req = 1'b0; pend_if = 0; end
    endcase
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) step();
      @(negedge clk);
      chk("wait_gnt", 32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
      chk("wait_mem", 32'({mem_en, mem_we}), 32'd0);
      chk("wait_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
    end
    @(negedge clk);
    if (who == 3) exp_if_rdata = rd;
    if (who == 2 && !e_we) exp_dm_rdata = rd;
    chk("resp_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'({who == 1, who == 2, who == 3}));
    chk("resp_gnt", 32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
    chk("resp_mem_en", 32'(mem_en), 32'd0);
    chk("resp_dm_rdata", dm_rdata, exp_dm_rdata);
    chk("resp_if_rdata", if_rdata, exp_if_rdata);
  endtask

  task automatic model_reset();
    pend_dbg = 0; pend_dm = 0; pend_if = 0;
    starve = 0; exp_dm_rdata = '0; exp_if_rdata = '0;
    m_dbg = 0; m_dm = 0; m_if = 0; m_conf = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [2:0] gv;
    logic [31:0] hold;
    rst = 1'b1;
    dbg_req = 0; dbg_addr = 0; dbg_wdata = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
    if_req = 0; if_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Debug and data collide: debug first, data issues at T+LAT+2
    step();
    req_dbg(32'h0, 32'h0050_0093);
    req_dm(1'b0, 32'h40, 32'h0, 4'h0);
    run_round(w, gv);
    chk("t2_dbg_first", 32'(gv), 32'b100);
    step();
    run_round(w, gv);
    chk("t2_dm_second", 32'(gv), 32'b010);
    chk("t2_dm_rdata", dm_rdata, init_val(6'h10));
`ifdef MEM_ARB_PERF_EN
    chk("t6_perf_dbg", perf_dbg_cnt, 32'd1);
    chk("t6_perf_dm", perf_dm_cnt, 32'd1);
    chk("t6_perf_conflict", perf_conflict_cnt, 32'd1);
    chk("t6_perf_if", perf_if_cnt, 32'd0);
`endif

    // Loader writes an instruction word, fetch reads it back
    step(); req_dbg(32'h10, 32'hDEAD_BEEF); run_round(w, gv);
    step(); req_if(32'h10); run_round(w, gv);
    chk("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);

    // Byte-strobed data write leaves dm_rdata alone, then read back merged word
    hold = dm_rdata;
    step(); req_dm(1'b1, 32'h80, 32'h1234_ABCD, 4'b0011); run_round(w, gv);
    chk("t4_dm_rdata_hold", dm_rdata, hold);
    step(); req_dm(1'b0, 32'h80, 32'h0, 4'h0); run_round(w, gv);
    chk("t4_merge", dm_rdata, {init_val(6'h20) & 32'hFFFF_0000} | 32'h0000_ABCD);

    // dm and fetch both held: dm wins LIMIT times, then fetch, repeatedly
    for (int i = 0; i < 10; i++) begin
      step();
      if (!pend_dm) req_dm(1'b0, 32'(32'h100 + i * 4) & 32'hFC, 32'h0, 4'h0);
      if (!pend_if) req_if(32'(i * 4));
      run_round(w, gv);
      chk("t3_order", 32'(gv), (i % 5 == 4) ? 32'b001 : 32'b010);
    end

    // Randomized request mixes
    for (int r = 0; r < 60; r++) begin
      step();
      if (!pend_dbg && $urandom_range(0, 5) == 0)
        req_dbg(32'($urandom_range(0, 63) << 2), $urandom);
      if (!pend_dm && $urandom_range(0, 2) != 0)
        req_dm(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) << 2), $urandom,
               4'($urandom_range(0, 15)));
      if (!pend_if && $urandom_range(0, 2) != 0)
        req_if(32'($urandom_range(0, 63) << 2));
      run_round(w, gv);
    end
    for (int k = 0; k < 4; k++) begin
      if (pend_dbg || pend_dm || pend_if) begin
        step();
        run_round(w, gv);
      end
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_dbg_total", perf_dbg_cnt, 32'(m_dbg));
    chk("perf_dm_total", perf_dm_cnt, 32'(m_dm));
    chk("perf_if_total", perf_if_cnt, 32'(m_if));
    chk("perf_conflict_total", perf_conflict_cnt, 32'(m_conf));
`endif

    // Reset in the middle of WAIT discards the pending fetch response
    step(); req_if(32'h20);
    @(negedge clk);
    chk("t5_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #2;
    if_req = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
      chk("t5_no_mem_en", 32'(mem_en), 32'd0);
    end
    step(); req_if(32'h24); run_round(w, gv);
    chk("t5_fresh_gnt", 32'(gv), 32'b001);
`ifdef MEM_ARB_PERF_EN
    chk("t5_perf_if", perf_if_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between three requesters: the debug loader, the MEMORY_ACCESS stage data port and the FETCH stage instruction port. It runs one access at a time, with a fixed memory latency. Arbitration is fixed-priority with anti-starvation for fetch. It sits between the pipeline stages and the memory macro, replacing the separate instruction and data memories.

Parameters:
XLEN, 32, data and address width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (>=1)
STARVE_LIMIT, 4, consecutive lost arbitrations before fetch is promoted over data (>=1)
LAT_CNT_W, 4, width of the latency counter (must hold MEM_LATENCY)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
dbg_req  in  1  debug request (write-only)
dbg_addr  in  XLEN  debug address
dbg_wdata  in  XLEN  debug write data
dbg_gnt  out  1  debug grant pulse
dbg_rvalid  out  1  debug completion pulse
dm_req  in  1  data request
dm_we  in  1  data write (1) / read (0)
dm_addr  in  XLEN  data address
dm_wdata  in  XLEN  data write data
dm_wstrb  in  4  data byte strobes
dm_gnt  out  1  data grant pulse
dm_rvalid  out  1  data response pulse
dm_rdata  out  XLEN  data read data
if_req  in  1  fetch request (read-only)
if_addr  in  XLEN  fetch address
if_gnt  out  1  fetch grant pulse
if_rvalid  out  1  fetch response pulse
if_rdata  out  XLEN  fetched instruction
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_wstrb  out  4  memory byte strobes
mem_rdata  in  XLEN  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE; every output=0; starve_cnt=0; owner=none; lat_cnt=0.
- FSM IDLE:
  - If any req is high, select the winner, drive mem_* from it combinationally and pulse its gnt in the same cycle. Go to WAIT with lat_cnt=1.
  - If no req is high, stay in IDLE with mem_en=0.
- FSM WAIT: lat_cnt increments each cycle. When lat_cnt==MEM_LATENCY, register mem_rdata into owner rdata. Go to RESP.
- FSM RESP:
  - Pulse the owner's rvalid for exactly one cycle, then go to IDLE.
  - rdata holds its value until the next response to the same requester.
  - For writes, rvalid is a completion ack and rdata is unchanged.
- Timing: issue at cycle T gives rvalid at T+MEM_LATENCY+1. The next issue is no earlier than T+MEM_LATENCY+2.
- Priority, in IDLE only: dbg > dm > if.
  - Exception: fetch beats dm when starve_cnt==STARVE_LIMIT. Debug always wins.
- starve_cnt:
  - +1 on each IDLE arbitration where if_req=1 and fetch loses, saturating at STARVE_LIMIT.
  - Cleared when fetch is granted.
  - Unchanged when if_req=0.
- Fixed fields per requester:
  - Debug: we=1, wstrb=1111.
  - Fetch: we=0, wstrb=0000, wdata=0.
- Outside the IDLE issue cycle, mem_en=0 and mem_we=0. mem_addr, mem_wdata and mem_wstrb are 0 when idle.
- Requesters hold req, addr and data stable until gnt. Dropping req before gnt is legal and has no effect. req held high after rvalid is a new request.
- Only one gnt and at most one rvalid are asserted per cycle. gnt is never given outside IDLE.
- No address alignment check; addr passes through unchanged.
- Reset mid-WAIT/RESP: returns to IDLE immediately and the pending response is discarded (no rvalid).

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_dbg_cnt, perf_dm_cnt, perf_if_cnt (32 bits each, grants per requester) and perf_conflict_cnt (32 bits, IDLE cycles with two or more reqs high).
  - All four wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. MEM_LATENCY=2. if_req with if_addr=0x10 at T, mem_rdata=0xDEADBEEF at T+2 -> if_gnt at T, mem_en=1/mem_addr=0x10 at T, if_rvalid=1 with if_rdata=0xDEADBEEF at T+3.
2. dbg_req (addr 0x0, data 0x00500093) and dm_req (read 0x40) both high at T -> dbg_gnt at T; dm_gnt at T+MEM_LATENCY+2; dm_rvalid at T+2*MEM_LATENCY+3.
3. dm_req and if_req held high continuously, STARVE_LIMIT=4 -> dm wins 4 arbitrations and fetch wins the 5th; starve_cnt is 0 afterwards.
4. dm write addr 0x80, wdata 0x1234ABCD, wstrb 0011 -> mem_we=1, mem_wstrb=0011, mem_wdata=0x1234ABCD at issue; dm_rvalid pulse; dm_rdata unchanged.
5. rst asserted during WAIT -> all outputs 0 asynchronously, no rvalid afterwards. A fresh if_req after reset is granted normally.
6. MEM_ARB_PERF_EN defined, scenario 2 repeated -> perf_dbg_cnt=1, perf_dm_cnt=1, perf_conflict_cnt=1, perf_if_cnt=0.
